// File: rtl/mem_image_loader_pkg.sv
// Shared types and ASCII constants for the program-image loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_image_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SKIPWS = 3'd1,
        ST_DIGITS = 3'd2,
        ST_COMMIT = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } ld_state_t;

    typedef enum logic [1:0] {
        FLD_OFFSET = 2'd0,
        FLD_PC     = 2'd1,
        FLD_DATA   = 2'd2
    } fld_t;

    localparam logic [7:0] CH_STAR = 8'h2A;  // '*' data offset
    localparam logic [7:0] CH_AT   = 8'h40;  // '@' initial PC
    localparam logic [7:0] CH_DASH = 8'h2D;  // '-' data word
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_TAB  = 8'h09;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_0    = 8'h30;
    localparam logic [7:0] CH_7    = 8'h37;
    localparam logic [7:0] CH_9    = 8'h39;
    localparam logic [7:0] CH_UA   = 8'h41;
    localparam logic [7:0] CH_UF   = 8'h46;
    localparam logic [7:0] CH_LA   = 8'h61;
    localparam logic [7:0] CH_LF_  = 8'h66;

    // Map a marker character to its record type; non-markers fall to data.
    function automatic fld_t fld_of(input logic [7:0] ch);
        if (ch == CH_STAR)    return FLD_OFFSET;
        else if (ch == CH_AT) return FLD_PC;
        else                  return FLD_DATA;
    endfunction

endpackage

// File: rtl/mem_image_loader_ascii_digit_decode.sv
// Classifies one ASCII character: digit (in RADIX) with value, whitespace, record marker.
// Latency: combinational.
// Backpressure: none.
module ascii_digit_decode
    import mem_image_loader_pkg::*;
#(
    parameter int RADIX = 8
) (
    input  logic [7:0] ch,
    output logic       is_digit,
    output logic [3:0] digit_val,
    output logic       is_ws,
    output logic       is_marker
);

    // Digit recognition; hex letters are case-insensitive and only legal in base 16.
    always_comb begin
        is_digit  = 1'b0;
        digit_val = 4'd0;
        if (ch >= CH_0 && ch <= CH_9) begin
            digit_val = 4'(ch - CH_0);
            is_digit  = (RADIX == 16) || (ch <= CH_7);
        end else if (ch >= CH_UA && ch <= CH_UF) begin
            digit_val = 4'(ch - CH_UA + 8'd10);
            is_digit  = (RADIX == 16);
        end else if (ch >= CH_LA && ch <= CH_LF_) begin
            digit_val = 4'(ch - CH_LA + 8'd10);
            is_digit  = (RADIX == 16);
        end
    end

    assign is_ws     = (ch == CH_SP) || (ch == CH_TAB) || (ch == CH_CR) || (ch == CH_LF);
    assign is_marker = (ch == CH_STAR) || (ch == CH_AT) || (ch == CH_DASH);

endmodule

// File: rtl/mem_image_loader.sv
// Parses an ASCII image stream ('*' offset, '@' pc, '-' word) into memory word writes.
// Latency: write request appears the cycle after the field's terminating char.
// Backpressure: char_ready drops during commit/write; write held stable until mem_wr_ready.
module mem_image_loader
    import mem_image_loader_pkg::*;
#(
    parameter int WORD_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int RADIX      = 8,
    parameter int MAX_DIGITS = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    input  logic              char_eof,
    output logic              char_ready,
    output logic              mem_wr_valid,
    input  logic              mem_wr_ready,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [WORD_W-1:0] mem_wr_data,
    output logic [ADDR_W-1:0] pc_start,
    output logic [ADDR_W-1:0] mem_last,
    output logic              done,
    output logic              syntax_err,
    output logic              ovf_err
);

    localparam int                SH    = (RADIX == 16) ? 4 : 3;
    localparam int                CW    = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0]     MAXD  = CW'(MAX_DIGITS);
    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(WORD_W / 8);

    ld_state_t         state_q, state_d;
    fld_t              fld_q, fld_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [CW-1:0]     dcnt_q, dcnt_d;
    logic [WORD_W-1:0] ofs_q, ofs_d;
    logic [WORD_W-1:0] ipc_q, ipc_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic              eof_q, eof_d;
    logic              syn_q, syn_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] pcs_q, pcs_d;
    logic [ADDR_W-1:0] last_q, last_d;
    // Holds char_ready low while reset is asserted so every output reads 0.
    logic              run_q, run_d;

    logic              is_digit, is_ws, is_marker;
    logic [3:0]        digit_val;
    logic [WORD_W-1:0] acc_next;
    logic              xfer;

    ascii_digit_decode #(.RADIX(RADIX)) u_dec (
        .ch        (char_data),
        .is_digit  (is_digit),
        .digit_val (digit_val),
        .is_ws     (is_ws),
        .is_marker (is_marker)
    );

    // Radix is a power of two, so the multiply is a shift; overflow truncates.
    assign acc_next = (acc_q << SH) + {{(WORD_W-4){1'b0}}, digit_val};
    assign xfer     = char_valid && char_ready;

    // State and datapath registers; reset abandons any field or write in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            fld_q   <= FLD_OFFSET;
            acc_q   <= '0;
            dcnt_q  <= '0;
            ofs_q   <= '0;
            ipc_q   <= '0;
            wcnt_q  <= '0;
            eof_q   <= 1'b0;
            syn_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            pcs_q   <= '0;
            last_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fld_q   <= fld_d;
            acc_q   <= acc_d;
            dcnt_q  <= dcnt_d;
            ofs_q   <= ofs_d;
            ipc_q   <= ipc_d;
            wcnt_q  <= wcnt_d;
            eof_q   <= eof_d;
            syn_q   <= syn_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            pcs_q   <= pcs_d;
            last_q  <= last_d;
            run_q   <= run_d;
        end
    end

    // Next-state: parse chars, then commit/write, then return to IDLE or finish on pending eof.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (is_marker) state_d = ST_SKIPWS;
                end else if (!char_valid && char_eof) begin
                    state_d = ST_DONE;
                end
            end
            ST_SKIPWS: begin
                if (char_valid) begin
                    if (is_digit)    state_d = ST_DIGITS;
                    else if (!is_ws) state_d = ST_IDLE;
                end else if (char_eof) begin
                    state_d = ST_DONE;
                end
            end
            ST_DIGITS: begin
                if (char_valid) begin
                    if (!is_digit) state_d = ST_COMMIT;
                end else if (char_eof) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (fld_q == FLD_DATA && !mem_wr_ready) state_d = ST_WRITE;
                else                                    state_d = eof_q ? ST_DONE : ST_IDLE;
            end
            ST_WRITE: begin
                if (mem_wr_ready) state_d = eof_q ? ST_DONE : ST_IDLE;
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath updates for the current state and character.
    always_comb begin
        fld_d  = fld_q;
        acc_d  = acc_q;
        dcnt_d = dcnt_q;
        ofs_d  = ofs_q;
        ipc_d  = ipc_q;
        wcnt_d = wcnt_q;
        eof_d  = eof_q;
        syn_d  = syn_q;
        ovf_d  = ovf_q;
        done_d = done_q;
        pcs_d  = pcs_q;
        last_d = last_q;
        run_d  = 1'b1;

        // Unconsumed chars (marker ending a field, junk after a bare marker) keep ready low.
        char_ready = 1'b0;
        case (state_q)
            ST_IDLE:   char_ready = run_q;
            ST_SKIPWS: char_ready = is_ws || is_digit;
            ST_DIGITS: char_ready = !is_marker;
            default:   char_ready = 1'b0;
        endcase

        mem_wr_valid = ((state_q == ST_COMMIT) && (fld_q == FLD_DATA)) || (state_q == ST_WRITE);

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (is_marker) begin
                        fld_d  = fld_of(char_data);
                        acc_d  = '0;
                        dcnt_d = '0;
                    end else if (!is_ws) begin
                        syn_d = 1'b1;
                    end
                end
            end
            ST_SKIPWS: begin
                if (char_valid) begin
                    if (is_digit) begin
                        acc_d  = {{(WORD_W-4){1'b0}}, digit_val};
                        dcnt_d = CW'(1);
                    end else if (!is_ws) begin
                        syn_d = 1'b1;
                    end
                end else if (char_eof) begin
                    syn_d = 1'b1;
                end
            end
            ST_DIGITS: begin
                if (char_valid) begin
                    if (is_digit) begin
                        if (dcnt_q < MAXD) begin
                            acc_d  = acc_next;
                            dcnt_d = dcnt_q + CW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else if (!is_ws && !is_marker) begin
                        syn_d = 1'b1;
                    end
                end else if (char_eof) begin
                    eof_d = 1'b1;
                end
            end
            ST_COMMIT: begin
                case (fld_q)
                    FLD_OFFSET: ofs_d = acc_q;
                    FLD_PC:     ipc_d = acc_q;
                    default:    if (mem_wr_ready) wcnt_d = wcnt_q + STEP;
                endcase
            end
            ST_WRITE: begin
                if (mem_wr_ready) wcnt_d = wcnt_q + STEP;
            end
            default: ;
        endcase

        // Result outputs are captured on the way into DONE so they are valid with done.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            done_d = 1'b1;
            pcs_d  = ADDR_W'(ofs_d) + ADDR_W'(ipc_d);
            last_d = wcnt_d;
        end
    end

    assign mem_wr_addr = wcnt_q;
    assign mem_wr_data = acc_q;
    assign pc_start    = pcs_q;
    assign mem_last    = last_q;
    assign done        = done_q;
    assign syntax_err  = syn_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_mem_image_loader.sv
// Directed bench for mem_image_loader: octal and hex instances, shared stimulus.
// Latency: n/a.
// Backpressure: drives mem_wr_ready low to exercise write hold.
module tb_mem_image_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, cv, ce, wr, sel;
    logic [7:0] cd;

    logic        cr8, cr16, wv8, wv16, dn8, dn16, se8, se16, oe8, oe16;
    logic [15:0] wa8, wa16, wd8, wd16, ps8, ps16, ml8, ml16;

    logic        cr, wv, dn, se, oe;
    logic [15:0] wa, wd, ps, ml;

    mem_image_loader #(.WORD_W(16), .ADDR_W(16), .RADIX(8), .MAX_DIGITS(6)) u_dut8 (
        .clock(clock), .reset(reset),
        .char_valid(cv & ~sel), .char_data(cd), .char_eof(ce & ~sel), .char_ready(cr8),
        .mem_wr_valid(wv8), .mem_wr_ready(wr), .mem_wr_addr(wa8), .mem_wr_data(wd8),
        .pc_start(ps8), .mem_last(ml8), .done(dn8), .syntax_err(se8), .ovf_err(oe8)
    );

    mem_image_loader #(.WORD_W(16), .ADDR_W(16), .RADIX(16), .MAX_DIGITS(6)) u_dut16 (
        .clock(clock), .reset(reset),
        .char_valid(cv & sel), .char_data(cd), .char_eof(ce & sel), .char_ready(cr16),
        .mem_wr_valid(wv16), .mem_wr_ready(wr), .mem_wr_addr(wa16), .mem_wr_data(wd16),
        .pc_start(ps16), .mem_last(ml16), .done(dn16), .syntax_err(se16), .ovf_err(oe16)
    );

    assign cr = sel ? cr16 : cr8;
    assign wv = sel ? wv16 : wv8;
    assign dn = sel ? dn16 : dn8;
    assign se = sel ? se16 : se8;
    assign oe = sel ? oe16 : oe8;
    assign wa = sel ? wa16 : wa8;
    assign wd = sel ? wd16 : wd8;
    assign ps = sel ? ps16 : ps8;
    assign ml = sel ? ml16 : ml8;

    int checks = 0;
    int errors = 0;

    logic [15:0] wq_a[$];
    logic [15:0] wq_d[$];

    // Record every accepted write, sampled away from the active edge.
    always @(negedge clock) begin
        if (wv && wr) begin
            wq_a.push_back(wa);
            wq_d.push_back(wd);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cv    = 1'b0;
        ce    = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        wq_a.delete();
        wq_d.delete();
        reset = 1'b1;
    endtask

    task automatic send_char(input logic [7:0] c);
        int n;
        cv = 1'b1;
        cd = c;
        #1;
        n = 0;
        while (!cr && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 100) chk("rdy_timeout", 32'd0, 32'd1);
        @(posedge clock);
        #1;
        cv = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic finish_eof();
        int n;
        ce = 1'b1;
        n  = 0;
        while (!dn && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 100) chk("done_timeout", 32'd0, 32'd1);
        ce = 1'b0;
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [15:0] a, input logic [15:0] d);
        if (idx < wq_a.size()) begin
            chk({tag, "_addr"}, {16'd0, wq_a[idx]}, {16'd0, a});
            chk({tag, "_data"}, {16'd0, wq_d[idx]}, {16'd0, d});
        end else begin
            chk({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        sel   = 1'b0;
        wr    = 1'b1;
        cd    = 8'h00;
        cv    = 1'b0;
        ce    = 1'b0;
        reset = 1'b1;
        #3;

        // Reset state: every output low.
        reset = 1'b0;
        #1;
        chk("rst_ready", {31'd0, cr}, 32'd0);
        chk("rst_valid", {31'd0, wv}, 32'd0);
        chk("rst_done",  {31'd0, dn}, 32'd0);
        chk("rst_errs",  {30'd0, se, oe}, 32'd0);
        chk("rst_pc",    {16'd0, ps}, 32'd0);
        chk("rst_last",  {16'd0, ml}, 32'd0);
        do_reset();

        // Octal load.
        send_str("*000000 @000010 -012737 -000001 ");
        finish_eof();
        chk("oct_nwr", wq_a.size(), 32'd2);
        chk_wr("oct_w0", 0, 16'h0000, 16'h15DF);
        chk_wr("oct_w1", 1, 16'h0002, 16'h0001);
        chk("oct_pc",   {16'd0, ps}, 32'h0008);
        chk("oct_last", {16'd0, ml}, 32'd4);
        chk("oct_done", {31'd0, dn}, 32'd1);
        chk("oct_errs", {30'd0, se, oe}, 32'd0);

        // Backpressure on the write port.
        do_reset();
        wr = 1'b0;
        send_str("-177777 ");
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'd0, wv}, 32'd1);
            chk("bp_addr",  {16'd0, wa}, 32'd0);
            chk("bp_data",  {16'd0, wd}, 32'h0000FFFF);
            chk("bp_ready", {31'd0, cr}, 32'd0);
            @(posedge clock);
            #1;
        end
        chk("bp_nwr_held", wq_a.size(), 32'd0);
        wr = 1'b1;
        @(posedge clock);
        #1;
        chk("bp_nwr", wq_a.size(), 32'd1);
        chk_wr("bp_w0", 0, 16'h0000, 16'hFFFF);
        chk("bp_valid_off", {31'd0, wv}, 32'd0);
        finish_eof();
        chk("bp_last", {16'd0, ml}, 32'd2);

        // Overflow and syntax errors.
        do_reset();
        send_str("-1234567 x@ ");
        finish_eof();
        chk("ovf_nwr", wq_a.size(), 32'd1);
        chk_wr("ovf_w0", 0, 16'h0000, 16'hA72E);
        chk("ovf_flag", {31'd0, oe}, 32'd1);
        chk("syn_flag", {31'd0, se}, 32'd1);
        chk("ovf_pc",   {16'd0, ps}, 32'd0);
        chk("ovf_done", {31'd0, dn}, 32'd1);
        chk("ovf_last", {16'd0, ml}, 32'd2);

        // Marker terminates a field and is reprocessed.
        do_reset();
        send_str("-7-5");
        finish_eof();
        chk("mk_nwr", wq_a.size(), 32'd2);
        chk_wr("mk_w0", 0, 16'h0000, 16'h0007);
        chk_wr("mk_w1", 1, 16'h0002, 16'h0005);
        chk("mk_last", {16'd0, ml}, 32'd4);
        chk("mk_errs", {30'd0, se, oe}, 32'd0);

        // Hex instance.
        sel = 1'b1;
        do_reset();
        send_str("*0100 @0020 -BEEF -cafe ");
        finish_eof();
        chk("hex_nwr", wq_a.size(), 32'd2);
        chk_wr("hex_w0", 0, 16'h0000, 16'hBEEF);
        chk_wr("hex_w1", 1, 16'h0002, 16'hCAFE);
        chk("hex_pc",   {16'd0, ps}, 32'h0120);
        chk("hex_last", {16'd0, ml}, 32'd4);
        chk("hex_errs", {30'd0, se, oe}, 32'd0);
        sel = 1'b0;

        // Reset while a write is stalled.
        do_reset();
        wr = 1'b0;
        send_str("-000005 ");
        chk("mr_valid_pre", {31'd0, wv}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mr_valid", {31'd0, wv}, 32'd0);
        chk("mr_addr",  {16'd0, wa}, 32'd0);
        chk("mr_data",  {16'd0, wd}, 32'd0);
        chk("mr_ready", {31'd0, cr}, 32'd0);
        chk("mr_done",  {31'd0, dn}, 32'd0);
        wr = 1'b1;
        @(posedge clock);
        #1;
        wq_a.delete();
        wq_d.delete();
        reset = 1'b1;
        send_str("-000003 ");
        finish_eof();
        chk("mr_nwr", wq_a.size(), 32'd1);
        chk_wr("mr_w0", 0, 16'h0000, 16'h0003);
        chk("mr_last", {16'd0, ml}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_image_loader.md
Name: mem_image_loader

Overview:
Synthesizable loader that parses an ASCII program-image character stream into memory word writes. It replaces the bench-side file parsing used today.
- Record markers: '*' = data offset, '@' = initial PC, '-' = data word.
- Sits between a character source (UART/file-feeder) and the memory write port, ahead of pdp_isa.
- Produces the start PC and last-written address that pdp_isa consumes once loading is done.

Parameters:
WORD_W, 16, width of data words and numeric fields.
ADDR_W, 16, byte-address width of memory port and PC outputs.
RADIX, 8, number base of digit fields; legal values 8 or 16.
MAX_DIGITS, 6, digits accepted per field; further digits set ovf_err and are discarded.

Ports:
clock  in  1  system clock; all state changes on rising edge.
reset  in  1  asynchronous, active-low reset.
char_valid  in  1  char_data valid this cycle.
char_data  in  8  ASCII character.
char_eof  in  1  end of stream; sampled only when no char is pending.
char_ready  out  1  loader accepts char_data this cycle.
mem_wr_valid  out  1  write request.
mem_wr_ready  in  1  memory accepts write.
mem_wr_addr  out  ADDR_W  byte address; word stored high byte at addr, low byte at addr+1.
mem_wr_data  out  WORD_W  word to write.
pc_start  out  ADDR_W  data_offset + init_pc, modulo 2^ADDR_W.
mem_last  out  ADDR_W  byte count written (next free address).
done  out  1  load complete; sticky until reset.
syntax_err  out  1  sticky: unknown char outside a field, or marker closed with zero digits.
ovf_err  out  1  sticky: field exceeded MAX_DIGITS.

Behaviour:
- Reset (reset low, async): all outputs 0; internal data_offset, init_pc and write counter = 0; state IDLE.
- A character transfer occurs when char_valid && char_ready. char_ready = 1 in IDLE, SKIPWS and DIGITS only.
- IDLE:
  - '*', '@' or '-' latches the field type, clears the accumulator and digit count, goes to SKIPWS.
  - Whitespace (space, tab, CR, LF) is ignored.
  - Any other char sets syntax_err, is consumed, and the state stays IDLE.
- SKIPWS: whitespace is consumed. A valid digit enters DIGITS with acc = digit. Any other char sets syntax_err and returns to IDLE without consuming that char; it is re-evaluated in IDLE next cycle.
- DIGITS:
  - Each digit updates acc = acc*RADIX + digit, truncated to WORD_W. The digit count saturates at MAX_DIGITS; digits beyond it set ovf_err and leave acc unchanged.
  - Hex digits are case-insensitive. For RADIX=8, '8'/'9' count as non-digits.
  - Whitespace terminates the field and goes to COMMIT.
  - A marker character terminates the field and goes to COMMIT without being consumed; it is reprocessed in IDLE.
  - Any other char sets syntax_err and goes to COMMIT, consumed.
- COMMIT, one cycle, char_ready = 0:
  - '*' loads data_offset = acc.
  - '@' loads init_pc = acc.
  - '-' presents mem_wr_valid = 1, mem_wr_addr = counter, mem_wr_data = acc, and moves to WRITE.
  - '*' and '@' return to IDLE.
- WRITE: mem_wr_valid, addr and data are held stable until mem_wr_ready. On the handshake, counter += WORD_W/8 (wraps modulo 2^ADDR_W) and the state returns to IDLE. The earliest write is one cycle after the terminating char.
- EOF:
  - char_eof in IDLE moves to DONE.
  - char_eof in DIGITS with no char pending goes to COMMIT first, then DONE after the commit or write completes.
  - char_eof in SKIPWS sets syntax_err and moves to DONE.
- DONE: done = 1, pc_start = data_offset + init_pc, mem_last = counter. These outputs are registered and valid in the same cycle done rises; they hold until reset. char_ready = 0.
- '*' and '@' may appear multiple times; the last value wins. They never move the write counter.
- Reset asserted mid-field or mid-write: the write is abandoned immediately, mem_wr_valid drops asynchronously, and no partial state survives.

Decomposition:
- Shared package (parameters): loader state enum (IDLE, SKIPWS, DIGITS, COMMIT, WRITE, DONE), field-type enum (FLD_OFFSET, FLD_PC, FLD_DATA), ASCII marker/whitespace constants.
- One sub-module: ascii_digit_decode, combinational. Takes char + RADIX and outputs is_digit, digit_val[3:0], is_ws, is_marker.

Test Plan:
- Octal load: stream "*000000 @000010 -012737 -000001 " then eof. Required: writes (0x0000, 0o012737), (0x0002, 0o000001); pc_start = 0o10; mem_last = 4; done = 1; both error flags 0.
- Backpressure: mem_wr_ready held 0 for 5 cycles on "-177777 ". Required: mem_wr_valid/addr/data stable throughout, char_ready = 0, exactly one write of 0xFFFF, counter advances 2 only after the handshake.
- Overflow and syntax: "-1234567 x@ " then eof. Required: write 0o123456, ovf_err = 1; 'x' sets syntax_err; "@ " then eof keeps syntax_err, init_pc stays 0, done = 1.
- Marker terminates field: "-7-5" then eof. Required: writes 7 at addr 0 and 5 at addr 2; mem_last = 4; no errors.
- RADIX=16, WORD_W=16: "*0100 @0020 -BEEF -cafe " then eof. Required: writes 0xBEEF at addr 0 and 0xCAFE at addr 2; pc_start = 0x0120.
- Reset mid-write: assert reset while mem_wr_valid = 1 and mem_wr_ready = 0. Required: all outputs 0 immediately; after release, "-000003 " then eof writes 3 to addr 0.
